// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle execute stage
// 1-cycle logic/arith, 1-bit/cycle shifts
module alu_exec_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic             dir_right;

  logic [SHW-1:0]   sh;
  logic             is_shift;
  logic             accept;
  logic [WIDTH-1:0] alu_val;
  logic [WIDTH-1:0] step;

  assign sh       = src_b[SHW-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) ||
                    (alu_ctrl == OP_SRL);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // single-cycle ops; reserved code yields zero
  always_comb begin
    alu_val = '0;
    unique case (1'b1)
      alu_ctrl == OP_ADD: alu_val = src_a + src_b;
      alu_ctrl == OP_SUB: alu_val = src_a - src_b;
      alu_ctrl == OP_XOR: alu_val = src_a ^ src_b;
      alu_ctrl == OP_OR:  alu_val = src_a | src_b;
      alu_ctrl == OP_AND: alu_val = src_a & src_b;
      default:            alu_val = '0;
    endcase
  end

  // one bit position in the captured direction
  always_comb begin
    step = work << 1;
    if (dir_right) step = work >> 1;
  end

  // control FSM with registered result/zero/out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      work      <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!is_shift) begin
              result    <= alu_val;
              zero      <= (alu_val == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (sh == '0) begin
              result    <= src_a;
              zero      <= (src_a == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              work      <= src_a;
              cnt       <= sh;
              dir_right <= alu_ctrl[2];
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= step;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result    <= step;
            zero      <= (step == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + random checks
// against a plain-arithmetic reference model
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_ctrl;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(
    input logic [2:0]   c,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    int s;
    s = int'(b % W);
    case (c)
      3'd0:    return a + b;
      3'd2:    return a - b;
      3'd1:    return a << s;
      3'd5:    return a >> s;
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(
    input logic [2:0]   c,
    input logic [W-1:0] b
  );
    if (c == 3'd1 || c == 3'd5)
      return int'(b % W) + 1;
    return 1;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // issue one op; hold = cycles of backpressure
  task automatic run_op(
    input string        tag,
    input logic [2:0]   c,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input int           hold
  );
    logic [W-1:0] exp;
    int           lat;
    exp = model(c, a, b);
    out_ready = (hold == 0);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 3'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk({tag, "_busy_ready"}, W'(in_ready), W'(0));
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, W'(lat),
        W'(model_lat(c, b)));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_zero"}, W'(zero), W'(exp == '0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      alu_ctrl = 3'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, W'(out_valid), W'(1));
      chk({tag, "_hold_result"}, result, exp);
      chk({tag, "_hold_ready"}, W'(in_ready), W'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (hold > 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    chk({tag, "_post_valid"}, W'(out_valid), W'(0));
    chk({tag, "_post_ready"}, W'(in_ready), W'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]   rc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = 3'd6;
    src_a     = 32'hFF;
    src_b     = 32'h1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("idle_valid", W'(out_valid), W'(0));
    chk("idle_result", result, '0);
    chk("idle_zero", W'(zero), W'(1));
    chk("idle_ready", W'(in_ready), W'(1));
    chk("idle_busy", W'(busy), W'(0));

    run_op("sub_eq", 3'd2, 32'd5, 32'd5, 0);
    run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sll31", 3'd1, 32'd1, 32'd31, 0);
    chk("sll31_val", result, 32'h8000_0000);
    run_op("srl5", 3'd5, 32'h8000_0000, 32'h25, 0);
    chk("srl5_val", result, 32'h0400_0000);
    run_op("srl0", 3'd5, 32'h1234, 32'h20, 0);
    chk("srl0_val", result, 32'h1234);
    run_op("resv", 3'd3, 32'hDEAD, 32'hBEEF, 0);
    run_op("or_bp", 3'd6, 32'hF0, 32'h0F, 10);
    chk("or_bp_val", result, 32'hFF);
    run_op("xor", 3'd4, 32'hA5A5, 32'hA5A5, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 3'd1;
    src_a     = 32'h3;
    src_b     = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_valid", W'(out_valid), W'(0));
    chk("mrst_result", result, '0);
    chk("mrst_zero", W'(zero), W'(1));
    chk("mrst_ready", W'(in_ready), W'(1));
    chk("mrst_busy", W'(busy), W'(0));
    repeat (25) begin
      @(posedge clk); #1;
      chk("mrst_quiet", W'(out_valid), W'(0));
    end
    run_op("and", 3'd7, 32'hC, 32'hA, 0);
    chk("and_val", result, 32'h8);

    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ra;
      run_op("rand", rc, ra, rb,
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
